branch_cdb: RTL and testbench

Branch result collector at the far end of the branch reservation station's result bus. It accepts resolved branch outcomes (RS slot number, taken flag, offset) and computes the redirect PC from a per-slot PC table written at dispatch. It queues redirects toward instruction fetch and returns a one-cycle finish pulse with the slot number so the station frees that entry. All state is on a single clock.

---
 rtl/branch_cdb_pkg.sv | 17 +
 rtl/branch_cdb_if.sv | 48 ++++
 rtl/branch_target_fifo.sv | 60 ++++++
 rtl/branch_cdb.sv | 93 +++++++++
 tb/tb_branch_cdb.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_cdb_pkg
// Description : Shared widths and constants for the branch result collector.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_cdb_pkg;

    localparam int   c_branch_rs_width = 3;    // branchALURSWidth
    localparam int   c_addr_width      = 32;   // addrWidth
    localparam int   c_fifo_depth      = 4;    // branchCDBFifoDepth
    localparam int   c_insn_bytes      = 4;
    localparam logic c_valid           = 1'b1;
    localparam logic c_invalid         = 1'b0;

endpackage
`default_nettype wire

// File: rtl/branch_cdb_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_cdb_if
// Description : Dispatch, branch-result, finish and redirect signals of the
//               branch result collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_cdb_if
    import branch_cdb_pkg::*;
#(
    parameter int RS_NUM_WIDTH = c_branch_rs_width,
    parameter int ADDR_WIDTH   = c_addr_width
);

    logic                    dispatch_valid;
    logic [RS_NUM_WIDTH-1:0] dispatch_rsnum;
    logic [ADDR_WIDTH-1:0]   dispatch_pc;
    logic                    result_valid;
    logic [RS_NUM_WIDTH-1:0] result_rsnum;
    logic                    result_taken;
    logic [ADDR_WIDTH-1:0]   result_offset;
    logic                    result_ready;
    logic                    finish;
    logic [RS_NUM_WIDTH-1:0] finish_rsnum;
    logic                    redirect_valid;
    logic [ADDR_WIDTH-1:0]   redirect_pc;
    logic                    redirect_ready;
    logic [31:0]             resolved_count;
    logic [31:0]             taken_count;

    modport master (
        output dispatch_valid, dispatch_rsnum, dispatch_pc,
        output result_valid, result_rsnum, result_taken, result_offset,
        output redirect_ready,
        input  result_ready, finish, finish_rsnum,
        input  redirect_valid, redirect_pc, resolved_count, taken_count
    );

    modport slave (
        input  dispatch_valid, dispatch_rsnum, dispatch_pc,
        input  result_valid, result_rsnum, result_taken, result_offset,
        input  redirect_ready,
        output result_ready, finish, finish_rsnum,
        output redirect_valid, redirect_pc, resolved_count, taken_count
    );

endinterface
`default_nettype wire

// File: rtl/branch_target_fifo.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_fifo
// Description : Circular redirect-target queue with occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [WIDTH-1:0] o_head
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    // The storage is not reset, so an empty queue presents zero instead.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/branch_cdb.sv
`default_nettype none
// ============================================================================
// Module      : branch_cdb
// Description : Branch result collector: computes redirect PCs from the slot
//               PC table, queues them to fetch and frees RS slots.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cdb
    import branch_cdb_pkg::*;
#(
    parameter int RS_NUM_WIDTH = c_branch_rs_width,
    parameter int ADDR_WIDTH   = c_addr_width,
    parameter int FIFO_DEPTH   = c_fifo_depth
) (
    input wire logic   clk,
    input wire logic   rst,
    branch_cdb_if.slave bus
);

    localparam int c_slots = 1 << RS_NUM_WIDTH;

    logic [ADDR_WIDTH-1:0]   r_pc_table [c_slots];
    logic [c_slots-1:0]      r_pending;
    logic                    r_finish;
    logic [RS_NUM_WIDTH-1:0] r_finish_rsnum;
    logic [31:0]             r_resolved_count;
    logic [31:0]             r_taken_count;

    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [ADDR_WIDTH-1:0]   w_fifo_head;
    logic                    w_slot_busy;
    logic                    w_ready;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_base_pc;
    logic [ADDR_WIDTH-1:0]   w_target;

    // A slot whose finish pulse is on the bus now is free again this cycle.
    assign w_slot_busy = r_pending[bus.result_rsnum] &&
                         !(r_finish && (r_finish_rsnum == bus.result_rsnum));
    assign w_ready     = !w_fifo_full && !w_slot_busy;
    assign w_accept    = bus.result_valid && w_ready;
    assign w_base_pc   = r_pc_table[bus.result_rsnum];
    assign w_target    = bus.result_taken ? (w_base_pc + bus.result_offset)
                                          : (w_base_pc + ADDR_WIDTH'(c_insn_bytes));

    always_ff @(posedge clk) begin
        if (bus.dispatch_valid) r_pc_table[bus.dispatch_rsnum] <= bus.dispatch_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending        <= '0;
            r_finish         <= c_invalid;
            r_finish_rsnum   <= '0;
            r_resolved_count <= '0;
            r_taken_count    <= '0;
        end else begin
            r_finish <= w_accept ? c_valid : c_invalid;
            if (r_finish) r_pending[r_finish_rsnum] <= 1'b0;
            if (w_accept) begin
                r_pending[bus.result_rsnum] <= 1'b1;
                r_finish_rsnum              <= bus.result_rsnum;
                r_resolved_count            <= r_resolved_count + 32'd1;
                if (bus.result_taken) r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    branch_target_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (w_target),
        .i_pop   (bus.redirect_ready),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    assign bus.result_ready   = w_ready;
    assign bus.finish         = r_finish;
    assign bus.finish_rsnum   = r_finish_rsnum;
    assign bus.redirect_valid = !w_fifo_empty;
    assign bus.redirect_pc    = w_fifo_head;
    assign bus.resolved_count = r_resolved_count;
    assign bus.taken_count    = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_cdb.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_cdb
// Description : Scoreboard bench for branch_cdb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_cdb;
    import branch_cdb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_cdb_if #(.RS_NUM_WIDTH(3), .ADDR_WIDTH(32)) bus ();

    branch_cdb #(
        .RS_NUM_WIDTH (3),
        .ADDR_WIDTH   (32),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fin_seen = 0;
    logic [31:0] exp_q [$];
    logic [31:0] m_pc [8];
    logic        m_fin = 1'b0;
    logic [2:0]  m_fin_slot = '0;
    logic [31:0] m_res = '0;
    logic [31:0] m_tak = '0;
    logic        drv_acc = 1'b0;
    logic        drv_taken = 1'b0;
    logic [2:0]  drv_slot = '0;
    logic [31:0] drv_target = '0;

    // Reference model: slot table, finish pulse, counters, expected redirects.
    always @(posedge clk) begin
        if (rst) begin
            m_fin      <= 1'b0;
            m_fin_slot <= '0;
            m_res      <= '0;
            m_tak      <= '0;
            exp_q.delete();
        end else begin
            m_fin <= drv_acc;
            if (drv_acc) begin
                m_fin_slot <= drv_slot;
                m_res      <= m_res + 32'd1;
                if (drv_taken) m_tak <= m_tak + 32'd1;
                exp_q.push_back(drv_target);
            end
        end
        if (bus.dispatch_valid) m_pc[bus.dispatch_rsnum] <= bus.dispatch_pc;
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (bus.finish !== m_fin) begin
                n_fail++;
                $display("FAIL finish: got %b expected %b", bus.finish, m_fin);
            end
            if (bus.finish === 1'b1) fin_seen++;
            if (m_fin) begin
                n_checks++;
                if (bus.finish_rsnum !== m_fin_slot) begin
                    n_fail++;
                    $display("FAIL finish_rsnum: got %0d expected %0d", bus.finish_rsnum, m_fin_slot);
                end
            end
            n_checks++;
            if (bus.resolved_count !== m_res || bus.taken_count !== m_tak) begin
                n_fail++;
                $display("FAIL counters: got %0d/%0d expected %0d/%0d",
                         bus.resolved_count, bus.taken_count, m_res, m_tak);
            end
            n_checks++;
            if (bus.redirect_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL redirect_valid: got %b expected %b", bus.redirect_valid, exp_q.size() != 0);
            end else if (exp_q.size() != 0) begin
                n_checks++;
                if (bus.redirect_pc !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL redirect_pc: got %h expected %h", bus.redirect_pc, exp_q[0]);
                end
                if (bus.redirect_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_dispatch(input logic [2:0] slot, input logic [31:0] pc);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_rsnum = slot;
        bus.dispatch_pc    = pc;
        step();
        bus.dispatch_valid = 1'b0;
    endtask

    task automatic present(input logic [2:0] slot, input logic taken,
                           input logic [31:0] off, input logic exp_ready);
        bus.result_valid  = 1'b1;
        bus.result_rsnum  = slot;
        bus.result_taken  = taken;
        bus.result_offset = off;
        drv_slot   = slot;
        drv_taken  = taken;
        drv_acc    = exp_ready;
        drv_target = taken ? m_pc[slot] + off : m_pc[slot] + 32'd4;
    endtask

    task automatic clear_result();
        bus.result_valid = 1'b0;
        drv_acc          = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.result_ready !== 1'b1 || bus.finish !== 1'b0 || bus.finish_rsnum !== 3'd0 ||
            bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b fin=%b slot=%0d rv=%b pc=%h expected 1 0 0 0 0",
                     bus.result_ready, bus.finish, bus.finish_rsnum, bus.redirect_valid, bus.redirect_pc);
        end
        n_checks++;
        if (bus.resolved_count !== 32'd0 || bus.taken_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.resolved_count, bus.taken_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_dispatch(3'd2, 32'h100);
        present(3'd2, 1'b1, 32'h20, 1'b1);
        #1;
        n_checks++;
        if (bus.result_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: got %b expected 1", bus.result_ready);
        end
        step();
        clear_result();
        n_checks++;
        if (bus.finish !== 1'b1 || bus.finish_rsnum !== 3'd2 || bus.redirect_pc !== 32'h120 ||
            bus.taken_count !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_result: got fin=%b slot=%0d pc=%h taken=%0d expected 1 2 00000120 1",
                     bus.finish, bus.finish_rsnum, bus.redirect_pc, bus.taken_count);
        end
        step();
        n_checks++;
        if (bus.finish !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse_width: got %b expected 0", bus.finish);
        end
    endtask

    task automatic test_wrap();
        do_dispatch(3'd5, 32'hFFFF_FFFC);
        present(3'd5, 1'b0, 32'h0, 1'b1);
        step();
        clear_result();
        n_checks++;
        if (bus.redirect_pc !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_not_taken: got %h expected 00000000", bus.redirect_pc);
        end
        step();
        present(3'd5, 1'b1, 32'hFFFF_FFF0, 1'b1);
        step();
        clear_result();
        n_checks++;
        if (bus.redirect_pc !== 32'hFFFF_FFEC) begin
            n_fail++;
            $display("FAIL wrap_taken: got %h expected ffffffec", bus.redirect_pc);
        end
        step();
    endtask

    task automatic test_full();
        logic [2:0] fill [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
        bus.redirect_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_dispatch(3'(i), 32'h1000 + 32'(i) * 32'h10);
        for (int i = 0; i < 4; i++) begin
            present(fill[i], fill[i][0], 32'h40, 1'b1);
            #1;
            n_checks++;
            if (bus.result_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready: got %b expected 1", bus.result_ready);
            end
            step();
        end
        present(3'd6, 1'b0, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (bus.result_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b expected 0", bus.result_ready);
        end
        step();
        bus.redirect_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.result_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_prepop_ready: got %b expected 0", bus.result_ready);
        end
        step();
        bus.redirect_ready = 1'b0;
        present(3'd6, 1'b0, 32'h0, 1'b1);
        step();
        bus.redirect_ready = 1'b1;
        present(3'd7, 1'b1, 32'h100, 1'b0);
        step();
        present(3'd7, 1'b1, 32'h100, 1'b1);
        step();
        bus.redirect_ready = 1'b0;
        present(3'd0, 1'b0, 32'h0, 1'b1);
        step();
        present(3'd1, 1'b1, 32'h8, 1'b0);
        #1;
        n_checks++;
        if (bus.result_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_occupancy: got ready %b expected 0", bus.result_ready);
        end
        step();
        clear_result();
        bus.redirect_ready = 1'b1;
        repeat (6) step();
        n_checks++;
        if (exp_q.size() != 0 || bus.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got %0d left valid=%b expected 0 left valid=0", exp_q.size(), bus.redirect_valid);
        end
    endtask

    task automatic test_same_slot();
        int f0;
        do_dispatch(3'd3, 32'h300);
        f0 = fin_seen;
        present(3'd3, 1'b0, 32'h0, 1'b1);
        step();
        present(3'd3, 1'b1, 32'h40, 1'b1);
        #1;
        n_checks++;
        if (bus.result_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL same_slot_finish_cycle: got ready %b expected 1", bus.result_ready);
        end
        step();
        clear_result();
        step();
        step();
        n_checks++;
        if (fin_seen - f0 != 2) begin
            n_fail++;
            $display("FAIL same_slot_pulses: got %0d expected 2", fin_seen - f0);
        end
    endtask

    task automatic test_same_cycle_dispatch();
        bus.dispatch_valid = 1'b1;
        bus.dispatch_rsnum = 3'd1;
        bus.dispatch_pc    = 32'h500;
        present(3'd1, 1'b0, 32'h0, 1'b1);
        step();
        bus.dispatch_valid = 1'b0;
        clear_result();
        n_checks++;
        if (bus.redirect_pc !== 32'h1014) begin
            n_fail++;
            $display("FAIL old_table_value: got %h expected 00001014", bus.redirect_pc);
        end
        step();
        present(3'd1, 1'b0, 32'h0, 1'b1);
        step();
        clear_result();
        n_checks++;
        if (bus.redirect_pc !== 32'h504) begin
            n_fail++;
            $display("FAIL new_table_value: got %h expected 00000504", bus.redirect_pc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.redirect_ready = 1'b0;
        present(3'd0, 1'b1, 32'h10, 1'b1);
        step();
        present(3'd2, 1'b0, 32'h0, 1'b1);
        step();
        present(3'd4, 1'b1, 32'h4, 1'b1);
        step();
        clear_result();
        n_checks++;
        if (bus.finish !== 1'b1 || bus.redirect_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_state: got fin=%b rv=%b expected 1 1", bus.finish, bus.redirect_valid);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.finish !== 1'b0 || bus.finish_rsnum !== 3'd0 || bus.redirect_valid !== 1'b0 ||
            bus.redirect_pc !== 32'd0 || bus.result_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got fin=%b slot=%0d rv=%b pc=%h rdy=%b expected 0 0 0 0 1",
                     bus.finish, bus.finish_rsnum, bus.redirect_valid, bus.redirect_pc, bus.result_ready);
        end
        n_checks++;
        if (bus.resolved_count !== 32'd0 || bus.taken_count !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_counters: got %0d/%0d expected 0/0", bus.resolved_count, bus.taken_count);
        end
        rst = 1'b0;
        bus.redirect_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        bus.dispatch_valid = 1'b0;
        bus.dispatch_rsnum = '0;
        bus.dispatch_pc    = '0;
        bus.result_valid   = 1'b0;
        bus.result_rsnum   = '0;
        bus.result_taken   = 1'b0;
        bus.result_offset  = '0;
        bus.redirect_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_same_slot();
        test_same_cycle_dispatch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
